vga_fbuf: RTL

//  Parametrised frame buffer between a pixel writer (CPU/drawing logic) and vga_ctrl.

---
 rtl/vga_fbuf.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_fbuf.sv
// vga_fbuf: frame buffer between a pixel writer and the VGA timing controller.
//   Linear-packed pixel storage with display-side pixel replication, a
//   registered one-cycle read, a valid/ready write port and a clear engine
//   that fills the writable page with a constant colour.
//
// Optional feature: define FBUF_DBL_BUF_EN for two pages (display reads the
//   front page; writes and clears go to the back page; swaps occur at
//   frame_start after a swap_req). Without it there is one page and
//   front_page is tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   h_addr, v_addr    display coordinates from the timing controller
//   rd_en             display active
//   vga_data          pixel for the coordinates presented one cycle earlier
//   wr_valid/ready    write handshake; wr_x, wr_y memory-space coordinates
//   wr_data           pixel to store
//   clr_start         one-cycle pulse starting a clear with clr_color
//   clr_busy          clear in progress
//   frame_start       start-of-vsync pulse (page swap point)
//   swap_req          request a page swap
//   front_page        page being displayed
module vga_fbuf #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned PIX_W      = 24,
   parameter int unsigned SCALE_LOG2 = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       h_addr,
   input  logic [9:0]       v_addr,
   input  logic             rd_en,
   output logic [PIX_W-1:0] vga_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [9:0]       wr_x,
   input  logic [9:0]       wr_y,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             clr_start,
   input  logic [PIX_W-1:0] clr_color,
   output logic             clr_busy,
   input  logic             frame_start,
   input  logic             swap_req,
   output logic             front_page
);

   localparam int unsigned MW    = H_RES >> SCALE_LOG2;
   localparam int unsigned MH    = V_RES >> SCALE_LOG2;
   localparam int unsigned DEPTH = MW * MH;
`ifdef FBUF_DBL_BUF_EN
   localparam int unsigned NPAGE = 2;
`else
   localparam int unsigned NPAGE = 1;
`endif
   localparam int unsigned WORDS = NPAGE * DEPTH;
   localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   logic [PIX_W-1:0] mem [WORDS];

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [PIX_W-1:0] fill, fill_nx;

   logic             back_page;
   logic             rd_hit;
   logic [AW-1:0]    rd_addr;
   logic             wr_hit;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [PIX_W-1:0] mem_wdata;

   assign clr_busy = (state == S_CLEAR);
   assign wr_ready = ~rst & ~clr_busy;

   // Clear engine state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         fill  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         fill  <= fill_nx;
      end
   end

   // Clear engine next state: one word per cycle, DEPTH cycles total
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fill_nx  = fill;
      case (state)
         S_IDLE: begin
            if (clr_start) begin
               state_nx = S_CLEAR;
               cnt_nx   = '0;
               fill_nx  = clr_color;
            end
         end
         S_CLEAR: begin
            if (cnt == CW'(DEPTH - 1)) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Display-side address: replicated coordinates into the front page
   always_comb begin
      rd_hit  = rd_en && (32'(h_addr) < H_RES) && (32'(v_addr) < V_RES);
      rd_addr = AW'(32'(v_addr >> SCALE_LOG2) * MW + 32'(h_addr >> SCALE_LOG2)
                    + 32'(front_page) * DEPTH);
   end

   // Write port mux: the clear engine owns the port while busy
   always_comb begin
      wr_hit    = wr_valid && wr_ready && (32'(wr_x) < MW) && (32'(wr_y) < MH);
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = wr_data;
      if (clr_busy) begin
         mem_we    = 1'b1;
         mem_waddr = AW'(32'(cnt) + 32'(back_page) * DEPTH);
         mem_wdata = fill;
      end else if (wr_hit) begin
         mem_we    = 1'b1;
         mem_waddr = AW'(32'(wr_y) * MW + 32'(wr_x) + 32'(back_page) * DEPTH);
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Registered read; a same-cycle write to the same word returns old data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_data <= '0;
      end else if (rd_hit) begin
         vga_data <= mem[rd_addr];
      end else begin
         vga_data <= '0;
      end
   end

`ifdef FBUF_DBL_BUF_EN
   logic fp_q, pend_q, armed_q;
   logic fp_nx, pend_nx, armed_nx;
   logic pend_any;
   logic swap_now;

   assign back_page  = ~fp_q;
   assign front_page = fp_q;

   // Page swap state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fp_q    <= 1'b0;
         pend_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         fp_q    <= fp_nx;
         pend_q  <= pend_nx;
         armed_q <= armed_nx;
      end
   end

   // A frame_start that arrives mid-clear arms the swap; it fires once the clear ends
   always_comb begin
      fp_nx    = fp_q;
      armed_nx = armed_q;
      pend_any = pend_q | swap_req;
      pend_nx  = pend_any;
      swap_now = !clr_busy && ((frame_start && pend_any) || armed_q);
      if (swap_now) begin
         fp_nx    = ~fp_q;
         pend_nx  = 1'b0;
         armed_nx = 1'b0;
      end else if (frame_start && pend_any && clr_busy) begin
         armed_nx = 1'b1;
      end
   end
`else
   logic unused_swap;

   assign back_page   = 1'b0;
   assign front_page  = 1'b0;
   assign unused_swap = swap_req ^ frame_start;
`endif

endmodule
